// File: rtl/rs_sl_queue_if.sv
// rs_sl_queue_if: bundles the dispatch, CDB snoop and issue signals of the
// load/store reservation station.
//   master : dispatch/CDB/buffer side, drives the *_i signals, sees busy and issue outputs
//   slave  : the reservation station itself
// Channel k of the CDB occupies cdb_id_i[k*ROB_W +: ROB_W] and
// cdb_data_i[k*XLEN +: XLEN].
interface rs_sl_queue_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 5,
    parameter int NCDB  = 3
);
    // dispatch
    logic                   en_i;
    logic [XLEN-1:0]        A_i;
    logic [XLEN-1:0]        B_i;
    logic                   A_rdy_i;
    logic                   B_rdy_i;
    logic [ROB_W-1:0]       A_id_i;
    logic [ROB_W-1:0]       B_id_i;
    logic [XLEN-1:0]        Imm_i;
    logic [6:0]             OP_i;
    logic [2:0]             Funct3_i;
    logic [ROB_W-1:0]       ROB_id_i;
    logic                   busy;
    // common data bus
    logic [NCDB-1:0]        cdb_en_i;
    logic [NCDB*ROB_W-1:0]  cdb_id_i;
    logic [NCDB*XLEN-1:0]   cdb_data_i;
    // issue to load/store buffer
    logic                   full_i;
    logic [XLEN-1:0]        A_o;
    logic [XLEN-1:0]        B_o;
    logic [XLEN-1:0]        Imm_o;
    logic [6:0]             OP_o;
    logic [2:0]             Funct3_o;
    logic [ROB_W-1:0]       ROB_id_o;
    logic                   en_o;

    modport master (
        output en_i, A_i, B_i, A_rdy_i, B_rdy_i, A_id_i, B_id_i,
               Imm_i, OP_i, Funct3_i, ROB_id_i,
               cdb_en_i, cdb_id_i, cdb_data_i, full_i,
        input  busy, A_o, B_o, Imm_o, OP_o, Funct3_o, ROB_id_o, en_o
    );

    modport slave (
        input  en_i, A_i, B_i, A_rdy_i, B_rdy_i, A_id_i, B_id_i,
               Imm_i, OP_i, Funct3_i, ROB_id_i,
               cdb_en_i, cdb_id_i, cdb_data_i, full_i,
        output busy, A_o, B_o, Imm_o, OP_o, Funct3_o, ROB_id_o, en_o
    );
endinterface

// File: rtl/rs_sl_queue.sv
// rs_sl_queue: DEPTH-entry in-order reservation station for loads/stores.
// Dispatch enqueues at the tail, pending operands snoop the CDB every cycle,
// and only the head issues to the load/store buffer once both its operands
// are ready (a CDB hit on the head in the same cycle counts as ready).
//   clk, rst_n : clock, async active-low reset
//   rst_c      : synchronous flush (empties the queue, keeps output data)
//   rdy        : global stall, low freezes all state
//   bus        : rs_sl_queue_if.slave (dispatch, CDB, issue)
module rs_sl_queue #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 5,
    parameter int DEPTH = 4,
    parameter int NCDB  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rst_c,
    input  logic          rdy,
    rs_sl_queue_if.slave  bus
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    // Lowest-index enabled channel with a matching tag wins; MSB is the hit flag.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_W-1:0]      tag,
        input logic [NCDB-1:0]       en,
        input logic [NCDB*ROB_W-1:0] ids,
        input logic [NCDB*XLEN-1:0]  data
    );
        logic [XLEN:0] r;
        r = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (en[k] && ids[k*ROB_W +: ROB_W] == tag) r = {1'b1, data[k*XLEN +: XLEN]};
        end
        return r;
    endfunction

    logic [DEPTH-1:0][XLEN-1:0]  a_q, b_q, imm_q;
    logic [DEPTH-1:0]            a_rdy_q, b_rdy_q;
    logic [DEPTH-1:0][ROB_W-1:0] a_id_q, b_id_q, rob_q;
    logic [DEPTH-1:0][6:0]       op_q;
    logic [DEPTH-1:0][2:0]       f3_q;
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [PW:0]                 cnt_q, cnt_d;

    logic [XLEN-1:0]  a_o_q, b_o_q, imm_o_q;
    logic [6:0]       op_o_q;
    logic [2:0]       f3_o_q;
    logic [ROB_W-1:0] rob_o_q;
    logic             en_o_q;

    logic [DEPTH-1:0]           a_hit, b_hit;
    logic [DEPTH-1:0][XLEN-1:0] a_snp, b_snp;
    logic                       dsp_a_hit, dsp_b_hit;
    logic [XLEN-1:0]            dsp_a_snp, dsp_b_snp;
    logic                       head_a_ok, head_b_ok;
    logic [XLEN-1:0]            head_a_val, head_b_val;
    logic                       enq, iss;

    always_comb begin
        a_hit = '0;
        b_hit = '0;
        a_snp = '0;
        b_snp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            {a_hit[i], a_snp[i]} = cdb_lookup(a_id_q[i], bus.cdb_en_i, bus.cdb_id_i, bus.cdb_data_i);
            {b_hit[i], b_snp[i]} = cdb_lookup(b_id_q[i], bus.cdb_en_i, bus.cdb_id_i, bus.cdb_data_i);
        end
        {dsp_a_hit, dsp_a_snp} = cdb_lookup(bus.A_id_i, bus.cdb_en_i, bus.cdb_id_i, bus.cdb_data_i);
        {dsp_b_hit, dsp_b_snp} = cdb_lookup(bus.B_id_i, bus.cdb_en_i, bus.cdb_id_i, bus.cdb_data_i);

        // Head may issue on a same-cycle CDB hit (bypass).
        head_a_ok  = a_rdy_q[head_q] | a_hit[head_q];
        head_b_ok  = b_rdy_q[head_q] | b_hit[head_q];
        head_a_val = a_rdy_q[head_q] ? a_q[head_q] : a_snp[head_q];
        head_b_val = b_rdy_q[head_q] ? b_q[head_q] : b_snp[head_q];

        // Enqueue uses the count before this edge: a slot freed by issue is not reusable yet.
        enq = rdy && bus.en_i && (cnt_q != CNT_FULL);
        iss = rdy && (cnt_q != '0) && !bus.full_i && head_a_ok && head_b_ok;

        head_d = iss ? head_q + PTR_ONE : head_q;
        tail_d = enq ? tail_q + PTR_ONE : tail_q;
        cnt_d  = cnt_q;
        if (enq && !iss) cnt_d = cnt_q + CNT_ONE;
        else if (!enq && iss) cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0; b_q <= '0; imm_q <= '0;
            a_rdy_q <= '0; b_rdy_q <= '0;
            a_id_q <= '0; b_id_q <= '0; rob_q <= '0;
            op_q <= '0; f3_q <= '0;
            head_q <= '0; tail_q <= '0; cnt_q <= '0;
            a_o_q <= '0; b_o_q <= '0; imm_o_q <= '0;
            op_o_q <= '0; f3_o_q <= '0; rob_o_q <= '0;
            en_o_q <= 1'b0;
        end else if (rst_c) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            en_o_q <= 1'b0;
        end else if (!rdy) begin
            en_o_q <= 1'b0;
        end else begin
            // Snoop every slot; empty slots are harmless and the tail write below overrides.
            for (int i = 0; i < DEPTH; i++) begin
                if (!a_rdy_q[i] && a_hit[i]) begin
                    a_q[i]     <= a_snp[i];
                    a_rdy_q[i] <= 1'b1;
                end
                if (!b_rdy_q[i] && b_hit[i]) begin
                    b_q[i]     <= b_snp[i];
                    b_rdy_q[i] <= 1'b1;
                end
            end
            if (enq) begin
                a_rdy_q[tail_q] <= bus.A_rdy_i | dsp_a_hit;
                b_rdy_q[tail_q] <= bus.B_rdy_i | dsp_b_hit;
                a_q[tail_q]     <= bus.A_rdy_i ? bus.A_i : dsp_a_snp;
                b_q[tail_q]     <= bus.B_rdy_i ? bus.B_i : dsp_b_snp;
                a_id_q[tail_q]  <= bus.A_id_i;
                b_id_q[tail_q]  <= bus.B_id_i;
                imm_q[tail_q]   <= bus.Imm_i;
                op_q[tail_q]    <= bus.OP_i;
                f3_q[tail_q]    <= bus.Funct3_i;
                rob_q[tail_q]   <= bus.ROB_id_i;
            end
            if (iss) begin
                a_o_q   <= head_a_val;
                b_o_q   <= head_b_val;
                imm_o_q <= imm_q[head_q];
                op_o_q  <= op_q[head_q];
                f3_o_q  <= f3_q[head_q];
                rob_o_q <= rob_q[head_q];
            end
            en_o_q <= iss;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.busy     = (cnt_q == CNT_FULL);
    assign bus.A_o      = a_o_q;
    assign bus.B_o      = b_o_q;
    assign bus.Imm_o    = imm_o_q;
    assign bus.OP_o     = op_o_q;
    assign bus.Funct3_o = f3_o_q;
    assign bus.ROB_id_o = rob_o_q;
    assign bus.en_o     = en_o_q;
endmodule

// File: doc/rs_sl_queue.md
# rs_sl_queue

Parametrised multi-entry reservation station for load/store instructions. It sits between the decode/dispatch stage and the load/store buffer. Dispatch writes into it, it snoops NCDB common-data-bus channels for pending operands, and it issues entries strictly in program order to the load/store buffer when the buffer is not full. Unlike the single-slot station it replaces, it holds DEPTH in-flight instructions and accepts a new one every cycle until full.

## Interface
- XLEN, 32, operand/immediate width
- ROB_W, 5, ROB tag width
- DEPTH, 4, entry count (power of 2, ≥2)
- NCDB, 3, number of CDB channels
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rst_c  in  1  synchronous flush (misprediction), active-high
- rdy  in  1  global stall; low freezes all state
- en_i  in  1  dispatch valid
- A_i, B_i  in  XLEN  operand values
- A_rdy_i, B_rdy_i  in  1  operand value valid
- A_id_i, B_id_i  in  ROB_W  producer ROB tag when not ready
- Imm_i  in  XLEN; OP_i  in  7; Funct3_i  in  3; ROB_id_i  in  ROB_W  instruction fields
- busy  out  1  high when count==DEPTH (dispatch must not assert en_i)
- cdb_en_i  in  NCDB  per-channel broadcast valid
- cdb_id_i  in  NCDB*ROB_W  channel k tag at bits [k*ROB_W +: ROB_W]
- cdb_data_i  in  NCDB*XLEN  channel k data at bits [k*XLEN +: XLEN]
- full_i  in  1  load/store buffer cannot accept
- A_o, B_o, Imm_o  out  XLEN; OP_o  out  7; Funct3_o  out  3; ROB_id_o  out  ROB_W  issued instruction
- en_o  out  1  issue strobe, one cycle per instruction

## Operation
- Storage: circular buffer, head/tail pointers of log2(DEPTH) bits, wrap modulo DEPTH, count of log2(DEPTH)+1 bits. Each entry holds A, B, A_rdy, B_rdy, A_id, B_id, Imm, OP, Funct3, ROB_id.
- Enqueue when rdy && en_i && count<DEPTH. en_i while count==DEPTH is ignored with no state change, even if issue frees a slot that cycle.
- Operand capture on enqueue, per operand: X_rdy_i wins; otherwise the lowest-index channel k with cdb_en_i[k] && tag match supplies data and sets ready; otherwise the entry stores the tag and is not ready.
- Snooping: every cycle, every valid non-ready operand takes data from the lowest-index matching enabled channel.
- Issue (in order, head only): when rdy && count>0 && !full_i, and both head operands are ready, registered or via a CDB match this cycle (bypass). Outputs are registered with the head contents, or the CDB data on bypass, en_o<=1, and head advances. Otherwise en_o<=0 and the output data registers hold their values.
- Younger ready entries never bypass a non-ready head.
- Simultaneous enqueue and issue: count unchanged. An entry enqueued at edge k is issue-eligible from edge k+1 onward.
- rdy low: pointers, count, entries and data outputs are frozen; en_o<=0.
- rst_c (sampled when rdy is either value): head=tail=0, count=0, en_o<=0. Data outputs are unchanged.
- rst_n low: asynchronously sets head=tail=count=0, en_o=0, A_o=B_o=Imm_o=0, OP_o=0, Funct3_o=0, ROB_id_o=0. busy=0 while in reset. Entry ready bits clear.

## Timing
- busy is combinational from the registered count only. It is not a function of en_i or full_i.
- Minimum latency: ready-at-dispatch enqueue at edge k, en_o high in the cycle after edge k+1.
- CDB bypass: a head operand broadcast in the cycle before edge k issues at edge k.
- Throughput: one enqueue and one issue per cycle.
- full_i is sampled at the issuing edge. The head is retained while full_i is high, and en_o stays low.
- Priority at an edge: rst_n > rst_c > rdy-low freeze > normal operation.

## Test plan
- Reset/idle: hold rst_n=0 then release → en_o=0, busy=0, all outputs 0. No issue with en_i=0.
- In-order with stall: enqueue ROB 1 (A pending on tag 7), then ROB 2 (ready) → no en_o. Broadcast cdb 2 tag 7 data 0x55 → next edge en_o=1 ROB_id_o=1 A_o=0x55, then ROB 2 issues on the following edge.
- Fill and wrap: DEPTH=4, enqueue 4 not-ready entries → busy=1, and a 5th en_i is dropped. Release all tags → 4 consecutive en_o pulses with ROB ids in order. Enqueue 4 more → pointers wrap, order preserved.
- CDB priority: channels 0 and 2 both broadcast tag 3 with 0xA and 0xC → waiting operand captures 0xA. With A_rdy_i=1 and A_i=0x1 and a matching CDB at dispatch → A=0x1.
- full_i backpressure: head ready and full_i=1 for 3 cycles → en_o=0 and count unchanged. Deassert → one en_o pulse with the correct fields.
- Flush and freeze: 3 entries queued, rdy=0 for 2 cycles with a CDB broadcast during it → no capture, en_o=0. Then rst_c=1 → count=0, busy=0, and no later issue of the flushed entries.
